// File: rtl/abacus_event_counter_bank.sv
// abacus_event_counter_bank
//   Wishbone-mapped bank of NUM_CHANNELS event counters for the ABACUS
//   profiler. Each counter is COUNTER_WIDTH bits wide. The block adds
//   per-channel gating, tear-free snapshots of every counter into shadow
//   registers, sticky overflow flags and a wrap or saturate mode.
//
//   Optional feature macro: ABACUS_OVERFLOW_IRQ_EN
//     defined   : IRQ_MASK register exists and irq = registered |(OVF & IRQ_MASK)
//     undefined : IRQ_MASK reads 0, writes to it are ignored, irq is tied 0
//
// Ports
//   clk       clock for everything
//   rst_n     asynchronous, active-low reset
//   event_in  one event per cycle on channel i while bit i is high
//   wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i  Wishbone classic request
//   wb_dat_o  registered read data, valid while wb_ack is high, 0 otherwise
//   wb_ack    single-cycle acknowledge
//   irq       level overflow interrupt
module abacus_event_counter_bank #(
  parameter int          NUM_CHANNELS  = 8,
  parameter int          COUNTER_WIDTH = 48,
  parameter logic [31:0] BASE_ADDR     = 32'hf0030000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] event_in,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [31:0]             wb_adr,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack,
  output logic                    irq
);

  localparam int CW = COUNTER_WIDTH;

  logic                    gen_q;
  logic                    sat_q;
  logic [NUM_CHANNELS-1:0] chan_en_q;
  logic [NUM_CHANNELS-1:0] ovf_vec;
  logic [31:0]             snap_seq_q;
  logic [CW-1:0]           live_arr   [NUM_CHANNELS];
  logic [CW-1:0]           shadow_arr [NUM_CHANNELS];

  logic        req;
  logic        hit;
  logic        wr_hit;
  logic [11:0] off;
  logic        ctrl_wr;
  logic        snap_pulse;
  logic        clr_pulse;
  logic        chan_en_wr;
  logic        ovf_w1c;
  logic [31:0] rdata;
  logic [4:0]  ch_idx;
  logic        ch_found;
  logic [63:0] snap_sel;
  logic [63:0] live_sel;
  logic        unused_bits;

  // A new request is accepted only when no ack is outstanding, which is
  // what spaces back-to-back requests to one every other cycle.
  assign req    = wb_cyc && wb_stb && !wb_ack;
  assign hit    = (wb_adr[31:12] == BASE_ADDR[31:12]);
  assign off    = wb_adr[11:0];
  assign wr_hit = req && wb_we && hit;
  assign ch_idx = off[7:3];

  assign ctrl_wr    = wr_hit && (off == 12'h000);
  assign snap_pulse = ctrl_wr && wb_dat_i[1];
  assign clr_pulse  = ctrl_wr && wb_dat_i[2];
  assign chan_en_wr = wr_hit && (off == 12'h004);
  assign ovf_w1c    = wr_hit && (off == 12'h008);

  assign unused_bits = ^{wb_adr[1:0], wb_dat_i};

  // Control, channel enable and snapshot sequence registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q      <= 1'b0;
      sat_q      <= 1'b0;
      chan_en_q  <= '0;
      snap_seq_q <= '0;
    end else begin
      if (ctrl_wr) begin
        gen_q <= wb_dat_i[0];
        sat_q <= wb_dat_i[3];
      end
      if (chan_en_wr) chan_en_q <= wb_dat_i[NUM_CHANNELS-1:0];
      if (snap_pulse) snap_seq_q <= snap_seq_q + 32'd1;
    end
  end

  // One live counter, shadow and sticky overflow flag per channel.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic [CW-1:0] count_q;
    logic [CW-1:0] shadow_q;
    logic          ovf_q;
    logic          inc;
    logic          at_max;

    assign inc    = gen_q && chan_en_q[i] && event_in[i];
    assign at_max = &count_q;

    // The shadow samples count_q before this edge's increment or clear,
    // so a snapshot always sees the pre-event, pre-clear value. Clear
    // beats a same-cycle event, and an overflow set beats a W1C.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q  <= '0;
        shadow_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (snap_pulse) shadow_q <= count_q;

        if (clr_pulse) begin
          count_q <= '0;
        end else if (inc) begin
          if (!at_max) begin
            count_q <= count_q + CW'(1);
          end else if (!sat_q) begin
            count_q <= '0;
          end
        end

        if (clr_pulse) begin
          ovf_q <= 1'b0;
        end else if (inc && at_max) begin
          ovf_q <= 1'b1;
        end else if (ovf_w1c && wb_dat_i[i]) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign live_arr[i]   = count_q;
    assign shadow_arr[i] = shadow_q;
    assign ovf_vec[i]    = ovf_q;
  end

`ifdef ABACUS_OVERFLOW_IRQ_EN
  logic [NUM_CHANNELS-1:0] irq_mask_q;
  logic                    irq_q;

  // Interrupt mask, plus an interrupt line registered one edge behind OVF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_hit && (off == 12'h00C)) irq_mask_q <= wb_dat_i[NUM_CHANNELS-1:0];
      irq_q <= |(ovf_vec & irq_mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux. Channel windows select low or high word with offset bit 2;
  // unknown offsets, absent channels and foreign windows read 0.
  always_comb begin
    rdata    = '0;
    snap_sel = '0;
    live_sel = '0;
    ch_found = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(ch_idx) == i) begin
        snap_sel = 64'(shadow_arr[i]);
        live_sel = 64'(live_arr[i]);
        ch_found = 1'b1;
      end
    end
    if (hit) begin
      case (off[11:8])
        4'h0: begin
          case (off[7:0])
            8'h00:   rdata = {28'd0, sat_q, 2'b00, gen_q};
            8'h04:   rdata = 32'(chan_en_q);
            8'h08:   rdata = 32'(ovf_vec);
`ifdef ABACUS_OVERFLOW_IRQ_EN
            8'h0C:   rdata = 32'(irq_mask_q);
`endif
            8'h10:   rdata = snap_seq_q;
            default: rdata = '0;
          endcase
        end
        4'h1:    if (ch_found) rdata = off[2] ? snap_sel[63:32] : snap_sel[31:0];
        4'h2:    if (ch_found) rdata = off[2] ? live_sel[63:32] : live_sel[31:0];
        default: rdata = '0;
      endcase
    end
  end

  // Ack and read data are registered together; data is forced to 0
  // whenever no ack is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= req;
      wb_dat_o <= req ? rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_abacus_event_counter_bank.sv
// tb_abacus_event_counter_bank
//   Directed self-checking bench for abacus_event_counter_bank, built with
//   eight 32-bit counters so wrap and saturate boundaries are reachable.
//   Counters are preset near all-ones with force/release on the channel
//   register, then stepped across the boundary with real events.
module tb_abacus_event_counter_bank;

  localparam logic [31:0] B = 32'hf0030000;
`ifdef ABACUS_OVERFLOW_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  event_in;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  abacus_event_counter_bank #(
    .NUM_CHANNELS (8),
    .COUNTER_WIDTH(32),
    .BASE_ADDR    (B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .event_in(event_in),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_we   (wb_we),
    .wb_adr  (wb_adr),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack  (wb_ack),
    .irq     (irq)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone transaction; waits a bounded number of cycles for ack.
  task automatic wbAccess(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic acked);
    @(negedge clk);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_dat_i = wdat;
    acked    = 1'b0;
    rdat     = '0;
    for (int k = 0; k < 8 && !acked; k++) begin
      @(posedge clk);
      #1;
      if (wb_ack) begin
        acked = 1'b1;
        rdat  = wb_dat_o;
      end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wbWrite(input string tag, input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] rd;
    logic        ak;
    wbAccess(1'b1, adr, wdat, rd, ak);
    checkOutput({tag, "_ack"}, 64'(ak), 64'd1);
  endtask

  task automatic wbRead(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ak;
    wbAccess(1'b0, adr, 32'd0, rd, ak);
    checkOutput({tag, "_ack"}, 64'(ak), 64'd1);
    checkOutput(tag, 64'(rd), 64'(exp));
  endtask

  // Holds event_in for exactly n active edges.
  task automatic applyStimulus(input logic [7:0] ev, input int n);
    @(negedge clk);
    event_in = ev;
    repeat (n) @(posedge clk);
    @(negedge clk);
    event_in = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    event_in = '0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_dat_i = '0;
    $display("[TB] start, IRQ feature = %0d", IRQ_EN);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", 64'(wb_ack), 64'd0);
    checkOutput("rst_dat", 64'(wb_dat_o), 64'd0);
    checkOutput("rst_irq", 64'(irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wbRead("rst_ctrl", B + 32'h000, 32'd0);
    wbRead("rst_seq",  B + 32'h010, 32'd0);

    // Basic counting with channel gating and a snapshot
    wbWrite("en05", B + 32'h004, 32'h05);
    wbWrite("gen",  B + 32'h000, 32'h1);
    applyStimulus(8'hFF, 10);
    wbWrite("snap", B + 32'h000, 32'h3);
    wbRead("snap_ch0",    B + 32'h100, 32'd10);
    wbRead("snap_ch0_hi", B + 32'h104, 32'd0);
    wbRead("snap_ch1",    B + 32'h108, 32'd0);
    wbRead("snap_ch2",    B + 32'h110, 32'd10);
    wbRead("seq1",        B + 32'h010, 32'd1);
    wbRead("ctrl_rd",     B + 32'h000, 32'h1);
    wbRead("chen_rd",     B + 32'h004, 32'h05);

    // Disabling a channel freezes it; the others keep counting
    wbWrite("en04", B + 32'h004, 32'h04);
    applyStimulus(8'hFF, 3);
    wbRead("frz_ch0",  B + 32'h200, 32'd10);
    wbRead("live_ch2", B + 32'h210, 32'd13);
    wbRead("shd_ch2",  B + 32'h110, 32'd10);

    // Wrap overflow from 0xFFFF_FFFE with three events
    wbWrite("clr1", B + 32'h000, 32'h5);
    wbWrite("en01", B + 32'h004, 32'h01);
    wbRead("clr_ch2", B + 32'h210, 32'd0);
    @(negedge clk);
    force dut.g_chan[0].count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.g_chan[0].count_q;
    applyStimulus(8'h01, 3);
    wbRead("wrap_ch0",    B + 32'h200, 32'd1);
    wbRead("wrap_ch0_hi", B + 32'h204, 32'd0);
    wbRead("wrap_ovf",    B + 32'h008, 32'h1);
    wbWrite("ovf_w1c", B + 32'h008, 32'h1);
    wbRead("ovf_clr", B + 32'h008, 32'h0);

    // Saturate holds all-ones and still flags overflow
    wbWrite("sat", B + 32'h000, 32'h9);
    @(negedge clk);
    force dut.g_chan[0].count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.g_chan[0].count_q;
    applyStimulus(8'h01, 5);
    wbRead("sat_ch0", B + 32'h200, 32'hFFFF_FFFF);
    wbRead("sat_ovf", B + 32'h008, 32'h1);
    wbRead("sat_ctrl", B + 32'h000, 32'h9);

    // Snapshot + clear + event in the same cycle
    wbWrite("clr2", B + 32'h000, 32'h5);
    wbWrite("en08", B + 32'h004, 32'h08);
    applyStimulus(8'h08, 7);
    wbRead("pre_ch3", B + 32'h218, 32'd7);
    @(negedge clk);
    @(negedge clk);
    event_in = 8'h08;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = 1'b1;
    wb_adr   = B;
    wb_dat_i = 32'h7;
    @(posedge clk);
    #1;
    checkOutput("coll_ack", 64'(wb_ack), 64'd1);
    event_in = '0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wbRead("coll_snap", B + 32'h118, 32'd7);
    wbRead("coll_live", B + 32'h218, 32'd0);
    wbRead("coll_seq",  B + 32'h010, 32'd2);
    wbRead("coll_ovf",  B + 32'h008, 32'd0);

    // Overflow interrupt on channel 1
    wbWrite("clr3", B + 32'h000, 32'h5);
    wbWrite("mask", B + 32'h00C, 32'h2);
    wbRead("mask_rd", B + 32'h00C, IRQ_EN ? 32'h2 : 32'h0);
    wbWrite("en02", B + 32'h004, 32'h02);
    @(negedge clk);
    force dut.g_chan[1].count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.g_chan[1].count_q;
    @(negedge clk);
    event_in = 8'h02;
    @(posedge clk);
    #1;
    event_in = '0;
    checkOutput("irq_lag", 64'(irq), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("irq_set", 64'(irq), 64'(IRQ_EN));
    wbRead("irq_ovf", B + 32'h008, 32'h2);
    wbWrite("irq_w1c", B + 32'h008, 32'h2);
    checkOutput("irq_hold", 64'(irq), 64'(IRQ_EN));
    @(posedge clk);
    #1;
    checkOutput("irq_drop", 64'(irq), 64'd0);

    // Bus edge cases: unmapped offset, absent channel, foreign window
    wbRead("unmapped", B + 32'h1F0, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ack_1cyc", 64'(wb_ack), 64'd0);
    checkOutput("dat_idle", 64'(wb_dat_o), 64'd0);
    wbRead("snap_ch8", B + 32'h140, 32'd0);
    wbRead("live_ch8", B + 32'h240, 32'd0);
    wbRead("foreign",  B + 32'h1000, 32'd0);

    // Reset asserted while an ack is presented
    @(negedge clk);
    @(negedge clk);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = B + 32'h010;
    @(posedge clk);
    #1;
    checkOutput("mid_ack", 64'(wb_ack), 64'd1);
    checkOutput("mid_dat", 64'(wb_dat_o), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack", 64'(wb_ack), 64'd0);
    checkOutput("mid_rst_dat", 64'(wb_dat_o), 64'd0);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wbRead("post_ctrl", B + 32'h000, 32'd0);
    wbRead("post_chen", B + 32'h004, 32'd0);
    wbRead("post_seq",  B + 32'h010, 32'd0);
    wbRead("post_snap", B + 32'h118, 32'd0);
    wbRead("post_mask", B + 32'h00C, 32'd0);
    checkOutput("post_irq", 64'(irq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
